// File: rtl/input_wrapper_pkg.sv
// Shared definitions for the input/output wrapper pair: state encoding and
// default geometry of the narrow bus.
package input_wrapper_pkg;

  // Default geometry; the output wrapper sizes its bus from IW_CHUNK_W too.
  localparam int IW_CHUNK_W    = 8;
  localparam int IW_NUM_CHUNKS = 4;
  localparam int IW_TIMEOUT    = 8;

  // State encoding, fixed so other blocks can decode it directly.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RECV = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RECV = ST_RECV,
    FULL = ST_FULL
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_wrapper_if.sv
// Bus-side and core-side handshake bundle of the input wrapper.
interface input_wrapper_if
  import input_wrapper_pkg::*;
#(
  parameter int CHUNK_W    = IW_CHUNK_W,
  parameter int NUM_CHUNKS = IW_NUM_CHUNKS
);

  logic [CHUNK_W-1:0]            in_data;
  logic                          in_valid;
  logic                          in_ack;
  logic [CHUNK_W*NUM_CHUNKS-1:0] word;
  logic                          ready;
  logic                          core_ack;
  logic                          busy;
  logic                          err;

  // Environment side: drives chunks and the core acknowledge.
  modport master (
    output in_data, in_valid, core_ack,
    input  in_ack, word, ready, busy, err
  );

  // Wrapper side.
  modport slave (
    input  in_data, in_valid, core_ack,
    output in_ack, word, ready, busy, err
  );

endinterface

// File: rtl/input_wrapper_cntrlr.sv
// FSM and counters of the input wrapper: sequences chunk collection,
// hands the word to the core and aborts stalled partial words.
module input_wrapper_cntrlr
  import input_wrapper_pkg::*;
#(
  parameter int NUM_CHUNKS = IW_NUM_CHUNKS,
  parameter int TIMEOUT    = IW_TIMEOUT,
  parameter int CNT_W      = cw(NUM_CHUNKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             core_ack,
  output logic             ld_slice,
  output logic [CNT_W-1:0] slice_sel,
  output logic             clr_word,
  output logic             in_ack,
  output logic             ready,
  output logic             busy,
  output logic             err
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [STALL_W-1:0] LAST_STALL = STALL_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [STALL_W-1:0] stall;

  // Accept whenever the source offers and a word slot is free; masked during
  // reset so nothing is acknowledged that will be thrown away.
  assign in_ack    = in_valid && !rst && (state != FULL);
  assign ld_slice  = in_ack;
  assign slice_sel = cnt;

  // Timeout fires at the edge ending the last tolerated low cycle.
  assign clr_word  = !rst && (state == RECV) && !in_valid && (stall == LAST_STALL);

  // Single FSM with registered Moore outputs; err defaults low so it pulses.
  always_ff @(posedge clk) begin
    err <= 1'b0;
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      stall <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          stall <= '0;
          if (in_valid) begin
            cnt   <= CNT_W'(1);
            state <= RECV;
            busy  <= 1'b1;
          end
        end
        RECV: begin
          if (in_valid) begin
            stall <= '0;
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= FULL;
              busy  <= 1'b0;
              ready <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (stall == LAST_STALL) begin
            cnt   <= '0;
            stall <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            stall <= stall + STALL_W'(1);
          end
        end
        FULL: begin
          stall <= '0;
          if (core_ack) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          stall <= '0;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_wrapper.sv
// Input wrapper: assembles NUM_CHUNKS narrow bus chunks (first chunk in the
// LSB) into one wide word and offers it to the core.
module input_wrapper
  import input_wrapper_pkg::*;
#(
  parameter int CHUNK_W    = IW_CHUNK_W,
  parameter int NUM_CHUNKS = IW_NUM_CHUNKS,
  parameter int TIMEOUT    = IW_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input_wrapper_if.slave    bus
);

  localparam int CNT_W = cw(NUM_CHUNKS);

  if (NUM_CHUNKS < 2) begin : g_bad_chunks
    $error("input_wrapper: NUM_CHUNKS must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("input_wrapper: TIMEOUT must be >= 1");
  end

  logic                                ld_slice;
  logic [CNT_W-1:0]                    slice_sel;
  logic                                clr_word;
  logic                                in_ack;
  logic                                ready;
  logic                                busy;
  logic                                err;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  word_q;

  input_wrapper_cntrlr #(
    .NUM_CHUNKS (NUM_CHUNKS),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_cntrlr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .core_ack  (bus.core_ack),
    .ld_slice  (ld_slice),
    .slice_sel (slice_sel),
    .clr_word  (clr_word),
    .in_ack    (in_ack),
    .ready     (ready),
    .busy      (busy),
    .err       (err)
  );

  // Word register: cleared on reset/timeout, otherwise one slice per accept.
  // Not cleared on core_ack; stale upper slices are don't-care until ready.
  always_ff @(posedge clk) begin
    if (rst || clr_word) begin
      word_q <= '0;
    end else if (ld_slice) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        if (slice_sel == CNT_W'(k)) word_q[k] <= bus.in_data;
      end
    end
  end

  assign bus.in_ack = in_ack;
  assign bus.word   = word_q;
  assign bus.ready  = ready;
  assign bus.busy   = busy;
  assign bus.err    = err;

endmodule

// File: tb/tb_input_wrapper.sv
// Directed bench for input_wrapper with a word scoreboard.
module tb_input_wrapper;

  localparam int CW = 8;
  localparam int NC = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   words_seen = 0;
  int   words_sent = 0;
  logic ready_d = 1'b0;
  logic [31:0] sb[$];

  input_wrapper_if #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) bus ();

  input_wrapper #(.CHUNK_W(CW), .NUM_CHUNKS(NC), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare the word each time ready rises.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ready === 1'b1 && ready_d === 1'b0) begin
      words_seen++;
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else chk("sb_word", 64'(bus.word), 64'(sb.pop_front()));
    end
    ready_d <= bus.ready;
  end

  // Send chunks first..NC-1 of w with gap idle cycles between chunks.
  task automatic send_word(input logic [31:0] w, input int gap, input int first);
    sb.push_back(w);
    words_sent++;
    for (int k = first; k < NC; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[k*CW +: CW];
      #1;
      chk("in_ack_chunk", 64'(bus.in_ack), 64'd1);
      chk("busy_chunk", 64'(bus.busy), 64'(k != 0));
      chk("ready_low", 64'(bus.ready), 64'd0);
      @(negedge clk);
      if (k < NC - 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          #1;
          chk("busy_gap", 64'(bus.busy), 64'd1);
          chk("err_gap", 64'(bus.err), 64'd0);
          @(negedge clk);
        end
      end
    end
    bus.in_valid = 1'b0;
    #1;
    chk("ready_up", 64'(bus.ready), 64'd1);
    chk("busy_full", 64'(bus.busy), 64'd0);
  endtask

  task automatic release_word();
    bus.core_ack = 1'b1;
    @(negedge clk);
    bus.core_ack = 1'b0;
    #1;
    chk("ready_fall", 64'(bus.ready), 64'd0);
    @(negedge clk);
  endtask

  task automatic send_two(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1; bus.in_data = a;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset with in_valid high
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    bus.core_ack = 1'b0;
    #1;
    chk("rst_in_ack0", 64'(bus.in_ack), 64'd0);
    @(negedge clk);
    chk("rst_in_ack1", 64'(bus.in_ack), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_word", 64'(bus.word), 64'd0);
    @(negedge clk);

    // 2: back-to-back chunks
    send_word(32'h44332211, 0, 0);
    chk("word_b2b", 64'(bus.word), 64'h44332211);
    @(negedge clk);
    chk("ready_hold", 64'(bus.ready), 64'd1);
    release_word();

    // 3: three idle cycles between chunks
    send_word(32'h44332211, 3, 0);
    chk("word_gap", 64'(bus.word), 64'h44332211);
    @(negedge clk);

    // 4: FULL blocks new chunks until core_ack
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      #1;
      chk("full_in_ack", 64'(bus.in_ack), 64'd0);
      chk("full_word", 64'(bus.word), 64'h44332211);
      chk("full_ready", 64'(bus.ready), 64'd1);
      @(negedge clk);
    end
    bus.core_ack = 1'b1;
    #1;
    chk("ack_cycle_in_ack", 64'(bus.in_ack), 64'd0);
    @(negedge clk);
    bus.core_ack = 1'b0;
    #1;
    chk("idle_ready", 64'(bus.ready), 64'd0);
    chk("idle_in_ack", 64'(bus.in_ack), 64'd1);
    @(negedge clk);
    chk("after55_slice", 64'(bus.word[7:0]), 64'h55);
    send_word(32'h88776655, 0, 1);
    release_word();

    // 5: timeout abort
    send_two(8'hAA, 8'hBB);
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("stall_err", 64'(bus.err), 64'd0);
      chk("stall_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    #1;
    chk("to_err", 64'(bus.err), 64'd1);
    chk("to_busy", 64'(bus.busy), 64'd0);
    chk("to_word", 64'(bus.word), 64'd0);
    @(negedge clk);
    chk("to_err_pulse", 64'(bus.err), 64'd0);
    send_word(32'h04030201, 0, 0);
    chk("word_after_to", 64'(bus.word), 64'h04030201);
    release_word();

    // 6: reset mid-word
    send_two(8'hAA, 8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.ready), 64'd0);
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    chk("mid_rst_word", 64'(bus.word), 64'd0);
    @(negedge clk);
    chk("mid_rst_err2", 64'(bus.err), 64'd0);
    send_word(32'h40302010, 0, 0);
    chk("word_after_rst", 64'(bus.word), 64'h40302010);
    release_word();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("words_seen", 64'(words_seen), 64'(words_sent));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
